// File: rtl/branch_pkg.sv
// Shared encodings for branch resolution: condition codes and the 2-bit BHT counter.
// Also holds the saturating counter transition used by the predictor table.
package branch_pkg;

   typedef enum logic [2:0] {
      SEL_BEQ  = 3'd0,
      SEL_BNE  = 3'd1,
      SEL_BLT  = 3'd2,
      SEL_BGE  = 3'd3,
      SEL_BLTU = 3'd4,
      SEL_BGEU = 3'd5
   } branch_sel_e;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_state_e;

   localparam bht_state_e BHT_RESET = WNT;

   // Saturating up/down step of one history counter.
   function automatic bht_state_e bht_next(input bht_state_e s, input logic taken);
      bht_state_e n;
      n = s;
      unique case (s)
         SNT:     n = taken ? WNT : SNT;
         WNT:     n = taken ? WT  : SNT;
         WT:      n = taken ? ST  : WNT;
         ST:      n = taken ? ST  : WT;
         default: n = BHT_RESET;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/branch_predict_resolve_if.sv
// Fetch-lookup, EX-resolve and statistics signals of branch_predict_resolve.
// master drives fetch/EX inputs; slave is the predictor/resolver itself.
interface branch_predict_resolve_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic [XLEN-1:0]  f_pc;
   logic             f_predict_taken;
   logic             ex_valid;
   logic             ex_branch;
   logic [2:0]       ex_branch_sel;
   logic [XLEN-1:0]  ex_rs1;
   logic [XLEN-1:0]  ex_rs2;
   logic [XLEN-1:0]  ex_pc;
   logic [XLEN-1:0]  ex_target;
   logic             ex_pred_taken;
   logic             ex_taken;
   logic             mispredict;
   logic [XLEN-1:0]  redirect_pc;
   logic [CNT_W-1:0] branch_count;
   logic [CNT_W-1:0] mispredict_count;

   modport master (
      output f_pc, ex_valid, ex_branch, ex_branch_sel, ex_rs1, ex_rs2,
             ex_pc, ex_target, ex_pred_taken,
      input  f_predict_taken, ex_taken, mispredict, redirect_pc,
             branch_count, mispredict_count
   );

   modport slave (
      input  f_pc, ex_valid, ex_branch, ex_branch_sel, ex_rs1, ex_rs2,
             ex_pc, ex_target, ex_pred_taken,
      output f_predict_taken, ex_taken, mispredict, redirect_pc,
             branch_count, mispredict_count
   );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation for the six conditional-branch codes.
// Unused codes resolve not-taken.
module branch_cond_eval
   import branch_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [2:0]      sel,
   output logic            cond
);

   logic eq, lt_s, lt_u;

   always_comb begin
      eq   = (rs1 == rs2);
      lt_s = ($signed(rs1) < $signed(rs2));
      lt_u = (rs1 < rs2);
   end

   always_comb begin
      cond = 1'b0;
      case (sel)
         SEL_BEQ:  cond = eq;
         SEL_BNE:  cond = ~eq;
         SEL_BLT:  cond = lt_s;
         SEL_BGE:  cond = ~lt_s;
         SEL_BLTU: cond = lt_u;
         SEL_BGEU: cond = ~lt_u;
         default:  cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_predict_resolve.sv
// Bimodal branch predictor with EX-stage resolution, registered flush/redirect
// and saturating branch / mispredict statistics.
module branch_predict_resolve
   import branch_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 16,
   parameter int CNT_W       = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   branch_predict_resolve_if.slave  bus
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   if (BHT_ENTRIES < 2 || (BHT_ENTRIES & (BHT_ENTRIES - 1)) != 0) begin : g_bad_entries
      $error("BHT_ENTRIES must be a power of two and at least 2");
   end

   bht_state_e       bht [BHT_ENTRIES];
   logic [IDX_W-1:0] f_idx;
   logic [IDX_W-1:0] ex_idx;

   logic             cond;
   logic             qualified;
   logic             taken;
   logic             mp_event;
   logic [XLEN-1:0]  fallthrough_pc;

   logic             mispredict_q;
   logic [XLEN-1:0]  redirect_q;
   logic [CNT_W-1:0] branch_cnt_q;
   logic [CNT_W-1:0] mispredict_cnt_q;

   logic             unused_pc_bits;

   branch_cond_eval #(.XLEN(XLEN)) u_cond (
      .rs1  (bus.ex_rs1),
      .rs2  (bus.ex_rs2),
      .sel  (bus.ex_branch_sel),
      .cond (cond)
   );

   // Only word-index bits select a counter; the rest of the fetch PC aliases.
   assign f_idx          = bus.f_pc[IDX_W+1:2];
   assign ex_idx         = bus.ex_pc[IDX_W+1:2];
   assign unused_pc_bits = ^bus.f_pc;

   // A registered mispredict marks the instruction now in EX as wrong-path.
   always_comb begin
      qualified      = bus.ex_valid & bus.ex_branch & ~mispredict_q;
      taken          = qualified & cond;
      mp_event       = qualified & (taken != bus.ex_pred_taken);
      fallthrough_pc = bus.ex_pc + XLEN'(4);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
            bht[i] <= BHT_RESET;
         end
      end else if (qualified) begin
         bht[ex_idx] <= bht_next(bht[ex_idx], taken);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mispredict_q <= 1'b0;
         redirect_q   <= '0;
      end else begin
         mispredict_q <= mp_event;
         if (mp_event) begin
            redirect_q <= taken ? bus.ex_target : fallthrough_pc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         if (qualified && branch_cnt_q != '1) begin
            branch_cnt_q <= branch_cnt_q + CNT_W'(1);
         end
         if (mp_event && mispredict_cnt_q != '1) begin
            mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
         end
      end
   end

   // Lookup reads the pre-edge table: an update this cycle shows up next cycle.
   assign bus.f_predict_taken  = bht[f_idx][1];
   assign bus.ex_taken         = taken;
   assign bus.mispredict       = mispredict_q;
   assign bus.redirect_pc      = redirect_q;
   assign bus.branch_count     = branch_cnt_q;
   assign bus.mispredict_count = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Bench for branch_predict_resolve: condition vector table, directed pipeline
// sequences and random traffic, all checked against a behavioural model.
module tb_branch_predict_resolve;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;

   branch_predict_resolve_if #(.XLEN(32), .CNT_W(16)) bus_a ();
   branch_predict_resolve_if #(.XLEN(32), .CNT_W(2))  bus_b ();

   branch_predict_resolve #(.XLEN(32), .BHT_ENTRIES(16), .CNT_W(16)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(bus_a)
   );
   branch_predict_resolve #(.XLEN(32), .BHT_ENTRIES(16), .CNT_W(2)) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(bus_b)
   );

   // stimulus
   logic        v, b, pred;
   logic [2:0]  sel;
   logic [31:0] rs1, rs2, pc, tgt, fpc;

   // reference model
   int          m_bht [16];
   bit          m_mp;
   logic [31:0] m_redir;
   int          m_bc, m_mc;

   int total = 0;
   int bad   = 0;
   logic last_taken, last_fpred;

   typedef struct {
      logic [2:0]  sel;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic        exp;
   } vec_t;
   vec_t tab [13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit m_cond(input logic [2:0] s, input logic [31:0] a, input logic [31:0] c);
      case (s)
         3'd0:    return a == c;
         3'd1:    return a != c;
         3'd2:    return $signed(a) < $signed(c);
         3'd3:    return $signed(a) >= $signed(c);
         3'd4:    return a < c;
         3'd5:    return a >= c;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int sat(input int c, input int mx);
      return (c > mx) ? mx : c;
   endfunction

   task automatic drive();
      bus_a.f_pc = fpc;  bus_a.ex_valid = v;  bus_a.ex_branch = b;  bus_a.ex_branch_sel = sel;
      bus_a.ex_rs1 = rs1; bus_a.ex_rs2 = rs2; bus_a.ex_pc = pc; bus_a.ex_target = tgt;
      bus_a.ex_pred_taken = pred;
      bus_b.f_pc = fpc;  bus_b.ex_valid = v;  bus_b.ex_branch = b;  bus_b.ex_branch_sel = sel;
      bus_b.ex_rs1 = rs1; bus_b.ex_rs2 = rs2; bus_b.ex_pc = pc; bus_b.ex_target = tgt;
      bus_b.ex_pred_taken = pred;
   endtask

   // One clock: check combinational outputs, clock, advance the model, check registers.
   task automatic step();
      bit q, t, nmp;
      int idx;
      drive();
      #1;
      q = v && b && !m_mp;
      t = q && m_cond(sel, rs1, rs2);
      last_taken = bus_a.ex_taken;
      last_fpred = bus_a.f_predict_taken;
      chk("ex_taken", {63'd0, last_taken}, {63'd0, t});
      chk("f_predict", {63'd0, last_fpred}, {63'd0, m_bht[int'((fpc >> 2) % 16)] >= 2});
      @(posedge clk);
      if (!reset_n) begin
         foreach (m_bht[i]) m_bht[i] = 1;
         m_mp = 0; m_redir = '0; m_bc = 0; m_mc = 0;
      end else begin
         nmp = 0;
         if (q) begin
            idx = int'((pc >> 2) % 16);
            m_bht[idx] = t ? ((m_bht[idx] == 3) ? 3 : m_bht[idx] + 1)
                           : ((m_bht[idx] == 0) ? 0 : m_bht[idx] - 1);
            m_bc++;
            if (t != pred) begin
               nmp = 1;
               m_redir = t ? tgt : pc + 32'd4;
               m_mc++;
            end
         end
         m_mp = nmp;
      end
      #1;
      chk("mispredict", {63'd0, bus_a.mispredict}, {63'd0, m_mp});
      chk("redirect_pc", {32'd0, bus_a.redirect_pc}, {32'd0, m_redir});
      chk("branch_count", {48'd0, bus_a.branch_count}, 64'(sat(m_bc, 65535)));
      chk("mispredict_count", {48'd0, bus_a.mispredict_count}, 64'(sat(m_mc, 65535)));
      chk("branch_count_w2", {62'd0, bus_b.branch_count}, 64'(sat(m_bc, 3)));
      chk("mispredict_count_w2", {62'd0, bus_b.mispredict_count}, 64'(sat(m_mc, 3)));
   endtask

   task automatic idle();
      v = 0; b = 0;
      step();
   endtask

   task automatic do_reset();
      reset_n = 0; v = 0; b = 0;
      step(); step();
      reset_n = 1;
   endtask

   task automatic br(input logic [2:0] s, input logic [31:0] a, input logic [31:0] c,
                     input logic [31:0] p, input logic [31:0] tg, input logic pr);
      v = 1; b = 1; sel = s; rs1 = a; rs2 = c; pc = p; tgt = tg; pred = pr;
      step();
   endtask

   initial begin
      tab[0]  = '{3'd0, 32'd5,        32'd5,        1'b1};
      tab[1]  = '{3'd0, 32'd5,        32'd6,        1'b0};
      tab[2]  = '{3'd1, 32'd5,        32'd6,        1'b1};
      tab[3]  = '{3'd2, 32'hFFFFFFFF, 32'd1,        1'b1};
      tab[4]  = '{3'd4, 32'hFFFFFFFF, 32'd1,        1'b0};
      tab[5]  = '{3'd3, 32'd1,        32'hFFFFFFFF, 1'b1};
      tab[6]  = '{3'd3, 32'h80000000, 32'h7FFFFFFF, 1'b0};
      tab[7]  = '{3'd4, 32'd1,        32'hFFFFFFFF, 1'b1};
      tab[8]  = '{3'd5, 32'hFFFFFFFF, 32'd1,        1'b1};
      tab[9]  = '{3'd5, 32'd3,        32'd3,        1'b1};
      tab[10] = '{3'd2, 32'd3,        32'd3,        1'b0};
      tab[11] = '{3'd6, 32'd5,        32'd5,        1'b0};
      tab[12] = '{3'd7, 32'd0,        32'd1,        1'b0};

      v = 0; b = 0; sel = 0; rs1 = 0; rs2 = 0; pc = 0; tgt = 0; pred = 0; fpc = 0;
      foreach (m_bht[i]) m_bht[i] = 1;
      m_mp = 0; m_redir = '0; m_bc = 0; m_mc = 0;
      reset_n = 0;
      drive();
      @(posedge clk);
      #1;
      do_reset();

      // reset state: every index weakly not-taken, counters clear
      for (int i = 0; i < 16; i++) begin
         fpc = 32'(i) << 2;
         idle();
         chk("reset_pred", {63'd0, last_fpred}, 64'd0);
      end
      chk("reset_bc", {48'd0, bus_a.branch_count}, 64'd0);
      chk("reset_mc", {48'd0, bus_a.mispredict_count}, 64'd0);

      // condition table
      for (int i = 0; i < 13; i++) begin
         br(tab[i].sel, tab[i].rs1, tab[i].rs2, 32'h1000 + 32'(i) * 4, 32'h2000, tab[i].exp);
         chk($sformatf("vec%0d", i), {63'd0, last_taken}, {63'd0, tab[i].exp});
      end

      // training at 0x40 with aliasing at 0x80
      do_reset();
      fpc = 32'h40;
      br(3'd0, 32'd1, 32'd1, 32'h40, 32'h500, 1'b0);
      idle();
      chk("train_flip", {63'd0, last_fpred}, 64'd1);
      fpc = 32'h80;
      idle();
      chk("train_alias", {63'd0, last_fpred}, 64'd1);
      fpc = 32'h40;
      br(3'd0, 32'd1, 32'd1, 32'h40, 32'h500, 1'b1);
      br(3'd0, 32'd1, 32'd1, 32'h40, 32'h500, 1'b1);
      br(3'd0, 32'd1, 32'd1, 32'h40, 32'h500, 1'b1);
      br(3'd1, 32'd1, 32'd1, 32'h40, 32'h500, 1'b1);
      idle();
      chk("train_strong", {63'd0, last_fpred}, 64'd1);

      // taken mispredict, then squashed follower
      do_reset();
      br(3'd0, 32'd7, 32'd7, 32'h100, 32'h200, 1'b0);
      chk("mp_flag", {63'd0, bus_a.mispredict}, 64'd1);
      chk("mp_redirect", {32'd0, bus_a.redirect_pc}, 64'h200);
      chk("mp_count", {48'd0, bus_a.mispredict_count}, 64'd1);
      br(3'd0, 32'd7, 32'd7, 32'h300, 32'h400, 1'b0);
      chk("squash_taken", {63'd0, last_taken}, 64'd0);
      chk("squash_mp", {63'd0, bus_a.mispredict}, 64'd0);
      chk("squash_redirect", {32'd0, bus_a.redirect_pc}, 64'h200);
      chk("squash_bc", {48'd0, bus_a.branch_count}, 64'd1);

      // not-taken redirect wraps
      idle();
      br(3'd1, 32'd5, 32'd5, 32'hFFFFFFFC, 32'h1234, 1'b1);
      chk("wrap_mp", {63'd0, bus_a.mispredict}, 64'd1);
      chk("wrap_redirect", {32'd0, bus_a.redirect_pc}, 64'h0);

      // counter saturation with CNT_W=2
      do_reset();
      for (int i = 0; i < 5; i++) br(3'd1, 32'd9, 32'd9, 32'h600 + 32'(i) * 4, 32'h0, 1'b0);
      chk("sat_w2", {62'd0, bus_b.branch_count}, 64'd3);
      chk("sat_w16", {48'd0, bus_a.branch_count}, 64'd5);

      // reset drops a pending mispredict
      br(3'd0, 32'd2, 32'd2, 32'h700, 32'h800, 1'b0);
      chk("pend_mp", {63'd0, bus_a.mispredict}, 64'd1);
      reset_n = 0;
      idle();
      chk("rst_drop_mp", {63'd0, bus_a.mispredict}, 64'd0);
      br(3'd0, 32'd2, 32'd2, 32'h700, 32'h800, 1'b0);
      chk("rst_block_mp", {63'd0, bus_a.mispredict}, 64'd0);
      chk("rst_bc", {48'd0, bus_a.branch_count}, 64'd0);
      reset_n = 1;

      // random traffic
      for (int n = 0; n < 600; n++) begin
         reset_n = ($urandom_range(0, 59) != 0);
         v    = $urandom_range(0, 3) != 0;
         b    = $urandom_range(0, 3) != 0;
         sel  = 3'($urandom_range(0, 7));
         rs1  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
         rs2  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
         pc   = ($urandom_range(0, 7) == 0) ? $urandom : (32'($urandom_range(0, 63)) << 2);
         tgt  = $urandom;
         pred = $urandom_range(0, 1) != 0;
         fpc  = 32'($urandom_range(0, 127)) << 2;
         step();
      end
      reset_n = 1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_predict_resolve.md
BRANCH_PREDICT_RESOLVE -- requirements
Module: branch_predict_resolve

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand/PC width.
REQ-002 The block SHALL have parameter BHT_ENTRIES, default 16, number of 2-bit history counters; power of two, at least 2.
REQ-003 The block SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port f_pc, input, XLEN bits: fetch-stage PC for the prediction lookup.
REQ-007 The block SHALL have port f_predict_taken, output, 1 bit: prediction for f_pc.
REQ-008 The block SHALL have ports ex_valid and ex_branch, inputs, 1 bit each: EX-stage instruction is valid and is a conditional branch.
REQ-009 The block SHALL have port ex_branch_sel, input, 3 bits: branch condition code.
REQ-010 The block SHALL have ports ex_rs1 and ex_rs2, inputs, XLEN bits each: compare operands.
REQ-011 The block SHALL have ports ex_pc and ex_target, inputs, XLEN bits each: branch PC and taken target.
REQ-012 The block SHALL have port ex_pred_taken, input, 1 bit: prediction carried down the pipeline with this branch.
REQ-013 The block SHALL have port ex_taken, output, 1 bit: resolved outcome (combinational).
REQ-014 The block SHALL have ports mispredict (output, 1 bit) and redirect_pc (output, XLEN bits): registered flush request and the correct next PC.
REQ-015 The block SHALL have ports branch_count and mispredict_count, outputs, CNT_W bits each: statistics.

Function
REQ-016 Condition codes SHALL be BEQ=0 (rs1==rs2), BNE=1, BLT=2 (signed <), BGE=3 (signed >=), BLTU=4 (unsigned <), BGEU=5 (unsigned >=); codes 6 and 7 resolve not-taken.
REQ-017 ex_taken SHALL be qualified = ex_valid & ex_branch & ~mispredict & condition(ex_branch_sel); otherwise 0.
REQ-018 The BHT index SHALL be PC[log2(BHT_ENTRIES)+1:2]; PC bits [1:0] and upper bits SHALL be ignored (aliasing permitted).
REQ-019 f_predict_taken SHALL equal the MSB of BHT[index(f_pc)], combinational read, no bypass: a same-cycle update to that entry SHALL NOT be visible until the next cycle.
REQ-020 On each qualified branch, the entry BHT[index(ex_pc)] SHALL update at the clock edge: increment if taken, decrement if not taken, saturating at 0 (strongly not-taken) and 3 (strongly taken).
REQ-021 mispredict SHALL assert the cycle after a qualified branch with ex_taken != ex_pred_taken, for exactly one cycle per event (latency 1).
REQ-022 redirect_pc SHALL register ex_target if the branch is taken, else ex_pc+4 (mod 2^XLEN); redirect_pc SHALL hold its value when there is no mispredict.
REQ-023 While mispredict is 1, the EX instruction is wrong-path: no BHT update, no counter update, no new mispredict.
REQ-024 branch_count SHALL increment per qualified branch and mispredict_count per mispredict event; both SHALL saturate at all-ones with no wrap.
REQ-025 Back-to-back qualified branches in consecutive cycles SHALL each update independently, except for the squashed cycle defined in REQ-023.

Reset
REQ-026 With reset_n low at a rising edge, all BHT entries SHALL become 01 (weakly not-taken), mispredict 0, redirect_pc 0, and both counters 0.
REQ-027 Reset SHALL take precedence over any simultaneous update; a reset asserted mid-stream SHALL drop a pending mispredict.

Structure
REQ-028 Package branch_pkg SHALL hold the branch_sel encodings and the 2-bit counter typedef (SNT=00, WNT=01, WT=10, ST=11).
REQ-029 The block SHALL contain one combinational sub-module, branch_cond_eval (XLEN-parametrised; inputs rs1, rs2, sel; output cond), instantiated once.

Verification
REQ-030 The bench SHALL check reset: after reset, f_predict_taken=0 for every index, and both counters are 0.
REQ-031 The bench SHALL check BLT: rs1=0xFFFFFFFF, rs2=1 gives ex_taken=1; BLTU with the same operands gives ex_taken=0.
REQ-032 The bench SHALL check training: four taken branches at pc 0x40 give entry states 10, 11, 11, 11, the f_pc=0x40 prediction flips to 1 after the first, and pc 0x80 (same index at 16 entries) aliases.
REQ-033 The bench SHALL check mispredict: ex_pred_taken=0 with a taken BEQ at pc 0x100 and target 0x200 gives mispredict=1 next cycle, redirect_pc=0x200, and mispredict_count=1; the following EX branch is ignored.
REQ-034 The bench SHALL check not-taken redirect: pred=1 with a not-taken BNE at pc 0xFFFFFFFC gives redirect_pc=0x00000000 (wrap).
REQ-035 The bench SHALL check saturation and reset: with CNT_W=2, five branches leave branch_count=3; reset_n low in the cycle a mispredict is pending leaves mispredict=0.
